// File: rtl/timestamp_capture.sv
// timestamp_capture: free-running cycle counter whose value is snapshotted
// into a small first-word-fall-through FIFO on every rising edge of trig.
//
// Output handshake: out_valid is high whenever the FIFO holds at least one
// entry and out_data then shows the oldest entry; an entry is consumed at a
// clock edge where out_valid and out_ready are both high. out_valid never
// depends combinationally on out_ready.
module timestamp_capture #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4   // power of 2, >= 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     trig,
   input  logic                     clr_ovf,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [WIDTH-1:0]         cnt,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic             trig_d;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   logic push;
   logic pop;
   logic full;
   logic push_ok;
   logic drop;

   // Edge detect, handshake and acceptance decisions. When full, a
   // same-cycle pop frees the slot the push needs, so the push is accepted.
   always_comb begin
      push    = trig & ~trig_d;
      full    = (level == FULL_LEVEL);
      pop     = out_valid & out_ready;
      push_ok = push & (~full | pop);
      drop    = push & full & ~pop;
   end

   assign out_valid = (level != '0);
   // Head is always a real register value (zeroed at reset), never X.
   assign out_data  = mem[rd_ptr];

   // Free-running counter; wraps silently modulo 2^WIDTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Previous trig level, so a held-high trig produces a single push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_d <= 1'b0;
      end else begin
         trig_d <= trig;
      end
   end

   // Storage: the pre-increment count of the push cycle goes to the tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push_ok) begin
         mem[wr_ptr] <= cnt;
      end
   end

   // Pointers advance modulo DEPTH (natural wrap of the AW-bit registers).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy: accepted pushes minus pops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= '0;
      end else begin
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed bench for timestamp_capture. A 32-bit instance covers capture,
// ordering, overflow and reset; a 4-bit instance on the same inputs covers
// counter wrap and frozen-counter captures.
module tb_timestamp_capture;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        trig;
   logic        clr_ovf;
   logic        out_ready;

   logic        out_valid;
   logic [31:0] out_data;
   logic [31:0] cnt;
   logic [2:0]  level;
   logic        ovf;

   logic        out_valid4;
   logic [3:0]  out_data4;
   logic [3:0]  cnt4;
   logic [2:0]  level4;
   logic        ovf4;

   int n_checks;
   int n_fail;

   timestamp_capture #(.WIDTH(32), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .clr_ovf(clr_ovf),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .cnt(cnt), .level(level), .ovf(ovf)
   );

   timestamp_capture #(.WIDTH(4), .DEPTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .clr_ovf(clr_ovf),
      .out_ready(out_ready), .out_valid(out_valid4), .out_data(out_data4),
      .cnt(cnt4), .level(level4), .ovf(ovf4)
   );

   // Clock: posedges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // One active edge, then sample/drive 1 time unit later.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reset with inputs idle (trig level chosen by caller); release between
   // edges so the next posedge is edge 1.
   task automatic do_reset(input logic trig_level);
      rst_n     = 1'b0;
      en        = 1'b0;
      trig      = trig_level;
      clr_ovf   = 1'b0;
      out_ready = 1'b0;
      tick(2);
      check("rst_cnt",   cnt,       0);
      check("rst_level", level,     0);
      check("rst_valid", out_valid, 0);
      check("rst_data",  out_data,  0);
      check("rst_ovf",   ovf,       0);
      rst_n = 1'b1;
   endtask

   // Single-cycle trig pulse followed by one idle cycle.
   task automatic pulse();
      trig = 1'b1;
      tick();
      trig = 1'b0;
      tick();
   endtask

   // Pop entries one per cycle and compare them against the expected queue.
   task automatic drain(input string tag, input logic [31:0] exp_q[$]);
      out_ready = 1'b1;
      foreach (exp_q[i]) begin
         check({tag, "_valid"}, out_valid, 1);
         check({tag, "_data"},  out_data,  exp_q[i]);
         tick();
      end
      out_ready = 1'b0;
      check({tag, "_empty"}, out_valid, 0);
      check({tag, "_level0"}, level, 0);
   endtask

   // Basic capture: trig rises at edge 5 with cnt=4.
   task automatic basic_capture(input string tag);
      en = 1'b1;
      tick(4);
      trig = 1'b1;
      tick();
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"},  out_data,  4);
      check({tag, "_level"}, level,     1);
      check({tag, "_cnt"},   cnt,       5);
      tick(10);
      check({tag, "_hold_level"}, level,    1);
      check({tag, "_hold_data"},  out_data, 4);
      check({tag, "_hold_cnt"},   cnt,      15);
      trig = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_q[$];
      n_checks = 0;
      n_fail   = 0;

      // 1. Basic capture
      do_reset(1'b0);
      basic_capture("basic");

      // 2. Drain order: pulses sampled at edges 2, 6, 9
      do_reset(1'b0);
      en = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         trig = (e == 2 || e == 6 || e == 9);
         tick();
      end
      trig = 1'b0;
      check("drain_level3", level, 3);
      out_ready = 1'b1;
      check("drain_d0", out_data, 1);
      tick();
      check("drain_d1", out_data, 5);
      check("drain_level2", level, 2);
      tick();
      check("drain_d2", out_data, 8);
      check("drain_level1", level, 1);
      tick();
      check("drain_valid0", out_valid, 0);
      check("drain_level0", level, 0);
      out_ready = 1'b0;

      // 3. Overflow: stamps 0,2,4,6 kept, 8 dropped
      do_reset(1'b0);
      en = 1'b1;
      for (int p = 0; p < 4; p++) pulse();
      check("ovf_level4", level, 4);
      check("ovf_pre", ovf, 0);
      pulse();
      check("ovf_set", ovf, 1);
      check("ovf_level_full", level, 4);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_clr", ovf, 0);
      trig    = 1'b1;
      clr_ovf = 1'b1;
      tick();
      trig    = 1'b0;
      clr_ovf = 1'b0;
      check("ovf_set_wins", ovf, 1);
      exp_q = '{0, 2, 4, 6};
      drain("ovf_drain", exp_q);

      // 4. Full with simultaneous push/pop: cnt=8 at edge 9
      do_reset(1'b0);
      en = 1'b1;
      for (int p = 0; p < 4; p++) pulse();
      trig      = 1'b1;
      out_ready = 1'b1;
      tick();
      trig      = 1'b0;
      out_ready = 1'b0;
      check("fullpp_level", level, 4);
      check("fullpp_ovf", ovf, 0);
      check("fullpp_head", out_data, 2);
      exp_q = '{2, 4, 6, 8};
      drain("fullpp_drain", exp_q);

      // 5. Wrap (4-bit instance) and frozen-counter captures
      do_reset(1'b0);
      en = 1'b1;
      tick(15);
      check("wrap_cnt15", cnt4, 15);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      en   = 1'b0;
      check("wrap_cnt0", cnt4, 0);
      check("wrap_stamp", out_data4, 15);
      check("wrap_cnt32", cnt, 16);
      tick();
      pulse();
      pulse();
      check("freeze_cnt", cnt4, 0);
      check("freeze_level", level4, 3);
      check("freeze_level32", level, 3);
      out_ready = 1'b1;
      check("freeze_d0", out_data4, 15);
      tick();
      check("freeze_d1", out_data4, 0);
      check("freeze_d1_32", out_data, 16);
      tick();
      check("freeze_d2", out_data4, 0);
      check("freeze_d2_32", out_data, 16);
      tick();
      out_ready = 1'b0;
      check("freeze_empty", out_valid4, 0);

      // 6. Async reset mid-operation with level=3 and ovf=1
      do_reset(1'b0);
      en = 1'b1;
      for (int p = 0; p < 5; p++) pulse();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("async_pre_level", level, 3);
      check("async_pre_ovf", ovf, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_cnt",   cnt,       0);
      check("async_level", level,     0);
      check("async_valid", out_valid, 0);
      check("async_data",  out_data,  0);
      check("async_ovf",   ovf,       0);
      en = 1'b0;
      tick(2);
      rst_n = 1'b1;
      basic_capture("post_rst");

      // 7. trig already high when reset releases counts as an edge
      do_reset(1'b1);
      tick();
      check("first_cycle_level", level, 1);
      check("first_cycle_data", out_data, 0);
      tick(3);
      check("first_cycle_hold", level, 1);
      trig = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
